blink_divider_multi: RTL and testbench

- Multi-channel programmable clock divider / LED blink generator; successor to the fixed single-channel 50M-count toggler.
- Each channel has its own runtime divide value and mode (toggle, pulse, one-shot).
- Per-channel enable and global sync-clear; configuration arrives over a valid/ready port.
- Sits between the board clock and LED/strobe consumers; ticks can also clock-enable other logic.

---
 rtl/blink_pkg.sv | 15 +
 rtl/blink_divider_multi_if.sv | 34 +++
 rtl/blink_channel.sv | 156 +++++++++++++++
 rtl/blink_divider_multi.sv | 58 +++++
 tb/tb_blink_divider_multi.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/blink_pkg.sv
// Shared types for the multi-channel blink divider: channel mode encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package blink_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_TOGGLE  = 2'd0,
    MODE_PULSE   = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_e;

endpackage

// File: rtl/blink_divider_multi_if.sv
// Configuration port of the blink divider: one request carries channel, divide value and mode.
// Latency: transfer happens on the clk edge where cfg_valid & cfg_ready are both high.
// Backpressure: slave drops cfg_ready while the addressed channel still holds an unapplied request.
interface blink_divider_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  import blink_pkg::*;

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  mode_e             cfg_mode;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_mode,
    output cfg_ready
  );

endinterface

// File: rtl/blink_channel.sv
// One divider channel: counter, config shadow and mode logic (toggle/pulse/one-shot/hold).
// Latency: tick/wave register one edge after the terminal count is sampled.
// Backpressure: pending stays high from config load until the shadow is applied.
// Ports: clk, rst_n (sync, active-low), en (run level), sync_clr, cfg_load/cfg_div/cfg_mode
//        (shadow write), pending (shadow occupied), tick, wave, wave_n.
module blink_channel
  import blink_pkg::*;
#(
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_div,
  input  mode_e            cfg_mode,
  output logic             pending,
  output logic             tick,
  output logic             wave,
  output logic             wave_n
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] sh_div_q, sh_div_d;
  mode_e            mode_q, mode_d;
  mode_e            sh_mode_q, sh_mode_d;
  logic             pending_q, pending_d;
  logic             armed_q, armed_d;
  logic             wave_q, wave_d;
  logic             wave_n_q;
  logic             tick_q, tick_d;
  logic             at_term;
  logic             run;
  logic             term;
  logic             apply;

  assign at_term = (cnt_q == div_q);

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    mode_d    = mode_q;
    sh_div_d  = sh_div_q;
    sh_mode_d = sh_mode_q;
    pending_d = pending_q;
    armed_d   = armed_q;
    wave_d    = wave_q;
    tick_d    = 1'b0;
    run       = 1'b0;
    term      = 1'b0;
    apply     = 1'b0;

    if (sync_clr) begin
      // Phase-align: outranks a terminal count on the same edge, so no tick.
      cnt_d   = '0;
      wave_d  = 1'b0;
      armed_d = 1'b1;
      apply   = pending_q;
    end else if (!en) begin
      // Holding armed while disabled is what re-arms a one-shot on ch_en falling.
      cnt_d   = '0;
      armed_d = 1'b1;
      apply   = pending_q;
    end else begin
      case (mode_q)
        MODE_TOGGLE: begin
          run  = 1'b1;
          term = at_term;
          if (at_term) wave_d = ~wave_q;
        end
        MODE_PULSE: begin
          run    = 1'b1;
          term   = at_term;
          wave_d = at_term;
        end
        MODE_ONESHOT: begin
          if (armed_q) begin
            // wave stays high through the tick cycle, then drops once disarmed.
            run    = 1'b1;
            term   = at_term;
            wave_d = 1'b1;
            if (at_term) armed_d = 1'b0;
          end else begin
            cnt_d  = '0;
            wave_d = 1'b0;
          end
        end
        default: begin
          // HOLD: counter and wave frozen; a waiting shadow is taken at once.
          apply = pending_q;
        end
      endcase

      if (run) begin
        if (term) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          apply  = pending_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    if (apply) begin
      div_d     = sh_div_q;
      mode_d    = sh_mode_q;
      cnt_d     = '0;
      armed_d   = 1'b1;
      pending_d = 1'b0;
    end

    // Load only happens while pending is low, so it never collides with apply;
    // a request accepted on an apply edge therefore waits for the next one.
    if (cfg_load) begin
      sh_div_d  = cfg_div;
      sh_mode_d = cfg_mode;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= DEFAULT_DIV;
      mode_q    <= MODE_TOGGLE;
      sh_div_q  <= DEFAULT_DIV;
      sh_mode_q <= MODE_TOGGLE;
      pending_q <= 1'b0;
      armed_q   <= 1'b1;
      wave_q    <= 1'b0;
      wave_n_q  <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      sh_div_q  <= sh_div_d;
      sh_mode_q <= sh_mode_d;
      pending_q <= pending_d;
      armed_q   <= armed_d;
      wave_q    <= wave_d;
      wave_n_q  <= ~wave_d;
      tick_q    <= tick_d;
    end
  end

  assign pending = pending_q;
  assign tick    = tick_q;
  assign wave    = wave_q;
  assign wave_n  = wave_n_q;

endmodule

// File: rtl/blink_divider_multi.sv
// Multi-channel programmable divider / LED blinker with per-channel runtime config.
// Latency: config applied at the channel's next terminal count (or next edge if idle/held/sync_clr).
// Backpressure: cfg_ready = ~pending of the addressed channel; out-of-range channels accept and drop.
// Ports: clk, rst_n (sync, active-low), cfg (config slave), ch_en, sync_clr, tick, wave, wave_n.
module blink_divider_multi
  import blink_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 49999999
) (
  input  logic                   clk,
  input  logic                   rst_n,
  blink_divider_multi_if.slave   cfg,
  input  logic [NUM_CH-1:0]      ch_en,
  input  logic                   sync_clr,
  output logic [NUM_CH-1:0]      tick,
  output logic [NUM_CH-1:0]      wave,
  output logic [NUM_CH-1:0]      wave_n
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] load;
  logic              ready;

  always_comb begin
    ready = 1'b1;
    load  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cfg.cfg_ch) == i) begin
        ready   = ~pending[i];
        load[i] = cfg.cfg_valid & ~pending[i];
      end
    end
  end

  assign cfg.cfg_ready = ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    blink_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (CNT_W'(DEFAULT_DIV))
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (ch_en[i]),
      .sync_clr (sync_clr),
      .cfg_load (load[i]),
      .cfg_div  (cfg.cfg_div),
      .cfg_mode (cfg.cfg_mode),
      .pending  (pending[i]),
      .tick     (tick[i]),
      .wave     (wave[i]),
      .wave_n   (wave_n[i])
    );
  end

endmodule

// File: tb/tb_blink_divider_multi.sv
// Bench for blink_divider_multi: directed config/enable sequences, expectations queued per edge.
// A negedge monitor pops every expectation due at the current edge and compares it.
module tb_blink_divider_multi;
  import blink_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ch_en;
  logic       sync_clr;
  logic [3:0] tick;
  logic [3:0] wave;
  logic [3:0] wave_n;

  int edge_cnt = 0;
  int checks   = 0;
  int errors   = 0;
  int base;

  typedef struct {
    int         e;
    logic [3:0] m;
    logic [3:0] tk;
    logic [3:0] wv;
    bit         rc;
    bit         rdy;
    string      nm;
  } exp_t;

  exp_t q[$];

  logic [3:0] t2 [12];
  logic [3:0] w2 [12];
  bit         r2 [12];

  blink_divider_multi_if #(.NUM_CH(4), .CNT_W(8)) bus ();

  blink_divider_multi #(
    .NUM_CH      (4),
    .CNT_W       (8),
    .DEFAULT_DIV (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg      (bus),
    .ch_en    (ch_en),
    .sync_clr (sync_clr),
    .tick     (tick),
    .wave     (wave),
    .wave_n   (wave_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int e, input logic [3:0] m, input logic [3:0] tk,
                      input logic [3:0] wv, input bit rc, input bit rdy, input string nm);
    exp_t x;
    x.e = e; x.m = m; x.tk = tk; x.wv = wv; x.rc = rc; x.rdy = rdy; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic send(input int ch, input logic [7:0] dv, input mode_e md);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = 2'(ch);
    bus.cfg_div   = dv;
    bus.cfg_mode  = md;
  endtask

  // Monitor: compare everything due at the edge just taken.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].e <= edge_cnt) begin
      exp_t x;
      x = q.pop_front();
      if (x.e < edge_cnt) begin
        checks++; errors++;
        $display("FAIL %s: expectation for edge %0d not compared (now %0d)", x.nm, x.e, edge_cnt);
      end else begin
        if (x.m != 4'h0) begin
          checks++;
          if ((tick & x.m) !== (x.tk & x.m)) begin
            errors++;
            $display("FAIL %s tick @edge %0d: got %b want %b", x.nm, x.e, tick & x.m, x.tk & x.m);
          end
          checks++;
          if ((wave & x.m) !== (x.wv & x.m)) begin
            errors++;
            $display("FAIL %s wave @edge %0d: got %b want %b", x.nm, x.e, wave & x.m, x.wv & x.m);
          end
          checks++;
          if ((wave_n & x.m) !== (~x.wv & x.m)) begin
            errors++;
            $display("FAIL %s wave_n @edge %0d: got %b want %b", x.nm, x.e, wave_n & x.m, ~x.wv & x.m);
          end
        end
        if (x.rc) begin
          checks++;
          if (bus.cfg_ready !== x.rdy) begin
            errors++;
            $display("FAIL %s cfg_ready @edge %0d: got %b want %b", x.nm, x.e, bus.cfg_ready, x.rdy);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (edge %0d)", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    ch_en         = 4'h0;
    sync_clr      = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = 2'd0;
    bus.cfg_div   = 8'd0;
    bus.cfg_mode  = MODE_TOGGLE;

    // Reset defaults, then div=3 toggling on every channel.
    wait_edges(3);
    base = edge_cnt;
    push(base, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, "reset");
    rst_n = 1'b1;
    ch_en = 4'hF;
    for (int k = 1; k <= 12; k++)
      push(base + k, 4'hF, (k % 4 == 0) ? 4'hF : 4'h0, ((k / 4) % 2 == 1) ? 4'hF : 4'h0,
           1'b0, 1'b0, "toggle_default");
    wait_edges(12);

    // Mid-period write to ch1, second write stalled until the first applies.
    base = edge_cnt;
    t2 = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h2, 4'h0, 4'hD, 4'h2, 4'h0, 4'h0, 4'hF};
    w2 = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h2, 4'h2, 4'hF, 4'hD, 4'hD, 4'hD, 4'h2};
    r2 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 12; k++)
      push(base + k + 1, 4'hF, t2[k], w2[k], 1'b1, r2[k], "handshake_ch1");
    wait_edges(1);
    send(1, 8'd1, MODE_TOGGLE);
    wait_edges(1);
    send(1, 8'd2, MODE_TOGGLE);
    wait_edges(3);
    bus.cfg_valid = 1'b0;
    wait_edges(7);

    // PULSE div=0 on ch0 via a disabled apply, then div=2 while running.
    base = edge_cnt;
    push(base + 1, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0, "pulse0_load");
    push(base + 2, 4'h1, 4'h0, 4'h0, 1'b1, 1'b1, "pulse0_apply");
    for (int k = 3; k <= 6; k++)
      push(base + k, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0, "pulse0_every");
    ch_en = 4'hE;
    send(0, 8'd0, MODE_PULSE);
    wait_edges(1);
    bus.cfg_valid = 1'b0;
    wait_edges(1);
    ch_en = 4'hF;
    wait_edges(4);
    base = edge_cnt;
    push(base + 1, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0, "pulse2_accept");
    push(base + 2, 4'h1, 4'h1, 4'h1, 1'b1, 1'b1, "pulse2_apply");
    for (int k = 3; k <= 8; k++)
      push(base + k, 4'h1, (k % 3 == 2) ? 4'h1 : 4'h0, (k % 3 == 2) ? 4'h1 : 4'h0,
           1'b0, 1'b0, "pulse2_period");
    send(0, 8'd2, MODE_PULSE);
    wait_edges(1);
    bus.cfg_valid = 1'b0;
    wait_edges(7);

    // ONESHOT div=5 on ch3, then re-arm through ch_en low/high.
    base = edge_cnt;
    push(base + 1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "oneshot_load");
    push(base + 2, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "oneshot_apply");
    for (int k = 3; k <= 14; k++)
      push(base + k, 4'h8, (k == 8) ? 4'h8 : 4'h0, (k <= 8) ? 4'h8 : 4'h0,
           1'b0, 1'b0, "oneshot_first");
    ch_en = 4'h7;
    send(3, 8'd5, MODE_ONESHOT);
    wait_edges(1);
    bus.cfg_valid = 1'b0;
    wait_edges(1);
    ch_en = 4'hF;
    wait_edges(12);
    base = edge_cnt;
    for (int k = 1; k <= 10; k++)
      push(base + k, 4'h8, (k == 7) ? 4'h8 : 4'h0, (k >= 2 && k <= 7) ? 4'h8 : 4'h0,
           1'b0, 1'b0, "oneshot_rearm");
    ch_en = 4'h7;
    wait_edges(1);
    ch_en = 4'hF;
    wait_edges(9);

    // sync_clr with ch2 pending, channels at mixed counts.
    base = edge_cnt;
    push(base + 1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "sync_pending");
    push(base + 2, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, "sync_clear");
    push(base + 3, 4'hF, 4'h0, 4'h8, 1'b0, 1'b0, "sync_after1");
    push(base + 4, 4'hF, 4'h4, 4'hC, 1'b0, 1'b0, "sync_after2");
    push(base + 5, 4'hF, 4'h3, 4'hF, 1'b0, 1'b0, "sync_after3");
    push(base + 6, 4'hF, 4'h4, 4'hA, 1'b0, 1'b0, "sync_after4");
    send(2, 8'd1, MODE_TOGGLE);
    wait_edges(1);
    bus.cfg_valid = 1'b0;
    sync_clr      = 1'b1;
    wait_edges(1);
    sync_clr = 1'b0;
    wait_edges(4);

    // One-cycle reset mid-period with a pending write on ch1.
    base = edge_cnt;
    push(base + 1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, "rst_pending");
    push(base + 2, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, "rst_state");
    for (int k = 3; k <= 10; k++)
      push(base + k, 4'hF, (k == 6 || k == 10) ? 4'hF : 4'h0, (k >= 6 && k <= 9) ? 4'hF : 4'h0,
           1'b0, 1'b0, "rst_restart");
    send(1, 8'd7, MODE_TOGGLE);
    wait_edges(1);
    bus.cfg_valid = 1'b0;
    rst_n         = 1'b0;
    wait_edges(1);
    rst_n = 1'b1;
    wait_edges(10);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, want 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
